// File: rtl/avalon_packet_enforcer.sv
// Avalon-ST packet-framing enforcer between an untrusted source and a trusted sink.
// The data path is combinational (zero latency). Orphan beats are discarded, and a
// packet cut short by a new SOP is closed with a synthetic error EOP. Packets longer
// than MAX_PKT_BEATS are truncated. Each violation raises a registered one-cycle
// pulse and increments a saturating counter.
module avalon_packet_enforcer #(
    parameter int DATA_WIDTH_IN_BYTES = 8,
    parameter int EMPTY_WIDTH         = $clog2(DATA_WIDTH_IN_BYTES),
    parameter int MAX_PKT_BEATS       = 256,
    parameter int CNT_WIDTH           = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDTH_IN_BYTES*8-1:0] in_data,
    input  logic [EMPTY_WIDTH-1:0]         in_empty,
    input  logic                           in_valid,
    input  logic                           in_sop,
    input  logic                           in_eop,
    output logic                           in_rdy,
    output logic [DATA_WIDTH_IN_BYTES*8-1:0] out_data,
    output logic [EMPTY_WIDTH-1:0]         out_empty,
    output logic                           out_valid,
    output logic                           out_sop,
    output logic                           out_eop,
    output logic                           out_error,
    input  logic                           out_rdy,
    input  logic                           clear_counters,
    output logic                           packet_didnt_started,
    output logic                           packet_in_packet,
    output logic                           packet_too_long,
    output logic [CNT_WIDTH-1:0]           orphan_cnt,
    output logic [CNT_WIDTH-1:0]           pip_cnt,
    output logic [CNT_WIDTH-1:0]           oversize_cnt
);

    localparam int BEAT_W = $clog2(MAX_PKT_BEATS + 1);
    localparam logic [BEAT_W-1:0] BEAT_LIMIT = BEAT_W'(MAX_PKT_BEATS);

    typedef enum logic [1:0] {
        WAIT_FOR_SOP = 2'd0,
        IN_PACKET    = 2'd1,
        DROP_TAIL    = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [BEAT_W-1:0] beat_cnt, beat_cnt_nxt;
    logic [BEAT_W-1:0] beat_pos;
    logic              drop_beat, insert_eop, fwd_beat, truncate;
    logic              orphan_evt, pip_evt, oversize_evt;

    // Increment a counter by one, holding it at all-ones.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic evt);
        return (evt && !(&cnt)) ? cnt + CNT_WIDTH'(1) : cnt;
    endfunction

    // Classify the current beat, then steer handshake, outputs and next state.
    always_comb begin
        // NOTE: every variable gets a default first so that no path leaves one unassigned, which would infer a latch.
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        orphan_evt   = 1'b0;
        pip_evt      = 1'b0;
        oversize_evt = 1'b0;
        in_rdy       = out_rdy;
        out_valid    = 1'b0;
        out_data     = '0;
        out_empty    = '0;
        out_sop      = 1'b0;
        out_eop      = 1'b0;
        out_error    = 1'b0;

        // Inside a packet an SOP means interruption; outside one a non-SOP beat has no home.
        insert_eop = (state == IN_PACKET) && in_sop;
        drop_beat  = (state != IN_PACKET) && !in_sop;
        fwd_beat   = in_valid && !drop_beat && !insert_eop;
        // Position of this beat in its packet. An SOP always opens at position 1.
        beat_pos   = in_sop ? BEAT_W'(1) : beat_cnt + BEAT_W'(1);
        // A legal EOP at the limit is not a truncation.
        truncate   = fwd_beat && !in_eop && (beat_pos == BEAT_LIMIT);

        if (in_valid) begin
            if (drop_beat) begin
                in_rdy = 1'b1;
                if (state == WAIT_FOR_SOP) begin
                    orphan_evt = 1'b1;
                end else if (in_eop) begin
                    state_nxt = WAIT_FOR_SOP;
                end
            end else if (insert_eop) begin
                // Hold the new SOP on the input while the open packet is closed.
                in_rdy    = 1'b0;
                out_valid = 1'b1;
                out_eop   = 1'b1;
                out_error = 1'b1;
                if (out_rdy) begin
                    pip_evt   = 1'b1;
                    state_nxt = WAIT_FOR_SOP;
                end
            end else begin
                out_valid = 1'b1;
                out_data  = in_data;
                out_sop   = in_sop;
                out_eop   = in_eop | truncate;
                out_error = truncate;
                out_empty = in_eop ? in_empty : '0;
                if (out_rdy) begin
                    beat_cnt_nxt = beat_pos;
                    if (in_eop) begin
                        state_nxt = WAIT_FOR_SOP;
                    end else if (truncate) begin
                        oversize_evt = 1'b1;
                        state_nxt    = DROP_TAIL;
                    end else begin
                        state_nxt = IN_PACKET;
                    end
                end
            end
        end
    end

    // State register, beat counter and one-cycle violation pulses.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
        if (rst) begin
            state                <= WAIT_FOR_SOP;
            beat_cnt             <= '0;
            packet_didnt_started <= 1'b0;
            packet_in_packet     <= 1'b0;
            packet_too_long      <= 1'b0;
        end else begin
            state                <= state_nxt;
            beat_cnt             <= beat_cnt_nxt;
            packet_didnt_started <= orphan_evt;
            packet_in_packet     <= pip_evt;
            packet_too_long      <= oversize_evt;
        end
    end

    // Saturating violation counters. A clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || clear_counters) begin
            orphan_cnt   <= '0;
            pip_cnt      <= '0;
            oversize_cnt <= '0;
        end else begin
            orphan_cnt   <= sat_inc(orphan_cnt, orphan_evt);
            pip_cnt      <= sat_inc(pip_cnt, pip_evt);
            oversize_cnt <= sat_inc(oversize_cnt, oversize_evt);
        end
    end

endmodule

// File: tb/tb_avalon_packet_enforcer.sv
// Self-checking bench for avalon_packet_enforcer. Directed scenarios are followed by a
// randomized run. Every cycle is compared against a packet-level reference model.
module tb_avalon_packet_enforcer;

    localparam int BYTES = 4;
    localparam int EW    = 2;
    localparam int MAXB  = 4;
    localparam int CW    = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic [BYTES*8-1:0] in_data = '0;
    logic [EW-1:0]     in_empty = '0;
    logic              in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
    logic              in_rdy;
    logic [BYTES*8-1:0] out_data;
    logic [EW-1:0]     out_empty;
    logic              out_valid, out_sop, out_eop, out_error;
    logic              out_rdy = 1'b1;
    logic              clear_counters = 1'b0;
    logic              packet_didnt_started, packet_in_packet, packet_too_long;
    logic [CW-1:0]     orphan_cnt, pip_cnt, oversize_cnt;

    avalon_packet_enforcer #(
        .DATA_WIDTH_IN_BYTES(BYTES),
        .EMPTY_WIDTH(EW),
        .MAX_PKT_BEATS(MAXB),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_empty(in_empty), .in_valid(in_valid),
        .in_sop(in_sop), .in_eop(in_eop), .in_rdy(in_rdy),
        .out_data(out_data), .out_empty(out_empty), .out_valid(out_valid),
        .out_sop(out_sop), .out_eop(out_eop), .out_error(out_error), .out_rdy(out_rdy),
        .clear_counters(clear_counters),
        .packet_didnt_started(packet_didnt_started),
        .packet_in_packet(packet_in_packet),
        .packet_too_long(packet_too_long),
        .orphan_cnt(orphan_cnt), .pip_cnt(pip_cnt), .oversize_cnt(oversize_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model. Mode: 0 = between packets, 1 = inside a packet, 2 = discarding a tail.
    int            m_mode = 0;
    int            m_len  = 0;
    logic [CW-1:0] m_orphan_cnt = '0, m_pip_cnt = '0, m_over_cnt = '0;
    logic          m_orphan_p = 1'b0, m_pip_p = 1'b0, m_over_p = 1'b0;
    int            n_mode, n_len;
    logic          ev_orphan, ev_pip, ev_over;
    logic          e_valid, e_sop, e_eop, e_err, e_rdy;
    logic [BYTES*8-1:0] e_data;
    logic [EW-1:0] e_empty;

    task automatic model_eval();
        int  pos;
        bit  cut;
        e_valid = 0; e_sop = 0; e_eop = 0; e_err = 0; e_data = '0; e_empty = '0;
        e_rdy = out_rdy;
        ev_orphan = 0; ev_pip = 0; ev_over = 0;
        n_mode = m_mode; n_len = m_len;
        if (in_valid) begin
            if (m_mode == 1 && in_sop) begin
                e_rdy = 0; e_valid = 1; e_eop = 1; e_err = 1;
                if (out_rdy) begin ev_pip = 1; n_mode = 0; end
            end else if (m_mode != 1 && !in_sop) begin
                e_rdy = 1;
                if (m_mode == 0) ev_orphan = 1;
                else if (in_eop) n_mode = 0;
            end else begin
                pos = in_sop ? 1 : m_len + 1;
                cut = !in_eop && (pos == MAXB);
                e_valid = 1; e_data = in_data; e_sop = in_sop;
                e_eop = in_eop || cut; e_err = cut;
                e_empty = in_eop ? in_empty : '0;
                if (out_rdy) begin
                    n_len  = pos;
                    n_mode = in_eop ? 0 : (cut ? 2 : 1);
                    ev_over = cut;
                end
            end
        end
    endtask

    task automatic model_commit();
        if (rst) begin
            m_mode = 0; m_len = 0;
            m_orphan_p = 0; m_pip_p = 0; m_over_p = 0;
            m_orphan_cnt = '0; m_pip_cnt = '0; m_over_cnt = '0;
        end else begin
            m_mode = n_mode; m_len = n_len;
            m_orphan_p = ev_orphan; m_pip_p = ev_pip; m_over_p = ev_over;
            if (clear_counters) begin
                m_orphan_cnt = '0; m_pip_cnt = '0; m_over_cnt = '0;
            end else begin
                if (ev_orphan && m_orphan_cnt != {CW{1'b1}}) m_orphan_cnt = m_orphan_cnt + 1'b1;
                if (ev_pip    && m_pip_cnt    != {CW{1'b1}}) m_pip_cnt    = m_pip_cnt + 1'b1;
                if (ev_over   && m_over_cnt   != {CW{1'b1}}) m_over_cnt   = m_over_cnt + 1'b1;
            end
        end
    endtask

    // One clock: compare the combinational outputs mid-cycle, then the registered ones after the edge.
    task automatic step();
        @(negedge clk);
        model_eval();
        check("out_valid", out_valid, e_valid);
        check("out_sop", out_sop, e_sop);
        if (in_valid) check("in_rdy", in_rdy, e_rdy);
        if (e_valid) begin
            check("out_eop", out_eop, e_eop);
            check("out_error", out_error, e_err);
            check("out_data", out_data, e_data);
            check("out_empty", out_empty, e_empty);
        end
        @(posedge clk);
        model_commit();
        #1;
        check("pulse_orphan", packet_didnt_started, m_orphan_p);
        check("pulse_pip", packet_in_packet, m_pip_p);
        check("pulse_too_long", packet_too_long, m_over_p);
        check("orphan_cnt", orphan_cnt, m_orphan_cnt);
        check("pip_cnt", pip_cnt, m_pip_cnt);
        check("oversize_cnt", oversize_cnt, m_over_cnt);
    endtask

    task automatic beat(input logic v, input logic s, input logic e, input logic [31:0] d,
                        input logic [EW-1:0] emp, input logic rdy, input logic clr = 1'b0);
        rst = 1'b0; in_valid = v; in_sop = s; in_eop = e; in_data = d;
        in_empty = emp; out_rdy = rdy; clear_counters = clr;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; clear_counters = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        // 1: clean 3-beat packet
        do_reset();
        check("reset_orphan_cnt", orphan_cnt, 16'h0);
        beat(1, 1, 0, 32'h11, 0, 1);
        beat(1, 0, 0, 32'h22, 0, 1);
        beat(1, 0, 1, 32'h33, 3, 1);
        check("t1_pip_cnt", pip_cnt, 16'h0);
        check("t1_oversize_cnt", oversize_cnt, 16'h0);

        // 2: orphans dropped even with sink stalled
        do_reset();
        beat(1, 0, 0, 32'h44, 1, 0);
        check("t2_pulse1", packet_didnt_started, 1'b1);
        beat(1, 0, 1, 32'h55, 2, 0);
        beat(0, 0, 0, 32'h0, 0, 1);
        check("t2_orphan_cnt", orphan_cnt, 16'h2);

        // 3: SOP inside a packet gets a synthetic EOP first
        do_reset();
        beat(1, 1, 0, 32'h01, 0, 1);
        beat(1, 0, 0, 32'h02, 0, 1);
        beat(1, 1, 0, 32'hAA, 0, 1);
        check("t3_pip_pulse", packet_in_packet, 1'b1);
        beat(1, 1, 0, 32'hAA, 0, 1);
        beat(1, 0, 1, 32'hBB, 1, 1);
        check("t3_pip_cnt", pip_cnt, 16'h1);

        // 4: 6-beat packet truncated at 4, tail dropped silently, next packet clean
        do_reset();
        beat(1, 1, 0, 32'h10, 0, 1);
        for (int i = 2; i <= 5; i++) beat(1, 0, 0, 32'h10 + i, 0, 1);
        beat(1, 0, 1, 32'h16, 2, 1);
        beat(1, 1, 1, 32'h20, 1, 1);
        check("t4_oversize_cnt", oversize_cnt, 16'h1);
        check("t4_orphan_cnt", orphan_cnt, 16'h0);

        // 5: orphan counter saturation and clear priority
        do_reset();
        for (int i = 0; i < 65535; i++) beat(1, 0, 0, i, 0, 1);
        check("t5_full", orphan_cnt, 16'hFFFF);
        beat(1, 0, 0, 32'h0, 0, 1);
        check("t5_hold", orphan_cnt, 16'hFFFF);
        beat(1, 0, 0, 32'h0, 0, 1, 1'b1);
        check("t5_clear", orphan_cnt, 16'h0);

        // 6: reset mid-packet abandons the packet
        do_reset();
        beat(1, 1, 0, 32'h77, 0, 1);
        do_reset();
        beat(1, 0, 0, 32'h78, 0, 1);
        check("t6_orphan_cnt", orphan_cnt, 16'h1);
        beat(1, 1, 1, 32'h79, 3, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst            = ($urandom_range(0, 199) == 0);
            in_valid       = ($urandom_range(0, 9) < 7);
            in_sop         = ($urandom_range(0, 3) == 0);
            in_eop         = ($urandom_range(0, 9) < 3);
            in_data        = $urandom;
            in_empty       = EW'($urandom);
            out_rdy        = ($urandom_range(0, 9) < 7);
            clear_counters = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
